// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, datapath
// mux selects, controller state enum and the debug view bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_TRAP   = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_EXEC,
        S_R_WB,
        S_ADDI_EX,
        S_ADDI_WB,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } ctrl_state_t;

    // Observation bundle for checkers: current state and resolved branch outcome.
    typedef struct packed {
        ctrl_state_t state;
        logic        branch_taken;
    } ctrl_dbg_t;

endpackage

// File: rtl/mips_retire_counter.sv
// Retired-instruction counter; increments on each retire pulse and wraps
// naturally from all-ones back to zero.
module mips_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for a shared-memory datapath, stalls on mem_ready and traps undefined opcodes.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int CNT_W   = 32,
    parameter bit EN_ADDI = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             trap_flag,
    output logic [CNT_W-1:0] instr_count,
    output ctrl_dbg_t        dbg
);

    ctrl_state_t state_q, state_d;
    logic        retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            trap_flag <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_TRAP) begin
                trap_flag <= 1'b1;
            end
        end
    end

    // Everything is gated by rst_n so an access in flight is dropped the
    // moment reset asserts, without waiting for a clock edge.
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PCSRC_ALU;
        alu_op        = ALU_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    case (opcode)
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = EN_ADDI ? S_ADDI_EX : S_TRAP;
                        default:      state_d = S_TRAP;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_req  = 1'b1;
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retire     = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    // The datapath qualifies pc_write_cond with zero; a not-taken beq still retires.
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    retire        = 1'b1;
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_JUMP;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
                S_TRAP: begin
                    pc_write  = 1'b1;
                    pc_source = PCSRC_TRAP;
                    state_d   = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    mips_retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instr_count)
    );

    assign dbg.state        = state_q;
    assign dbg.branch_taken = (state_q == S_BRANCH) && zero;

endmodule
